led_blink_coder: RTL

//  Output-side counterpart of the board button inputs: converts a small status code from the

---
 rtl/led_coder_pkg.sv | 30 +++
 rtl/led_interval_timer.sv | 31 +++
 rtl/led_blink_coder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/led_coder_pkg.sv
// Shared definitions for the LED blink coder: FSM state encoding,
// interval timer sizing and the LED output polarity helper.
package led_coder_pkg;

    // Frame phases: idle, LED lit, dark between blinks, long dark gap after the frame
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } blink_state_t;

    // Width of a down-counter able to hold the longest interval minus one
    function automatic int timerWidth(input int onCycles, input int offCycles, input int gapCycles);
        int longest;
        int width;
        longest = onCycles;
        if (offCycles > longest) longest = offCycles;
        if (gapCycles > longest) longest = gapCycles;
        width = $clog2(longest + 1);
        if (width < 1) width = 1;
        return width;
    endfunction

    // Map "LED should be lit" onto the pin level for the chosen polarity
    function automatic logic ledLevel(input logic lit, input bit activeHigh);
        return activeHigh ? lit : ~lit;
    endfunction

endpackage

// File: rtl/led_interval_timer.sv
// Loadable down-counter used to time the ON, OFF and GAP intervals.
// Loading LEN-1 on entry to a phase makes the zero flag rise on that
// phase's last cycle; the count holds at zero until reloaded.
module led_interval_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_zero,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over counting; the counter parks at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero  = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/led_blink_coder.sv
// Turns a small status code into a repeating LED pattern: N short blinks
// followed by a long dark gap. All outputs are registered and reflect the
// phase the FSM is in during the same cycle.
module led_blink_coder
    import led_coder_pkg::*;
#(
    parameter int CODE_W      = 4,
    parameter int ON_CYCLES   = 3_000_000,
    parameter int OFF_CYCLES  = 3_000_000,
    parameter int GAP_CYCLES  = 12_000_000,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_enable,
    input  logic [CODE_W-1:0] io_code,
    output logic              io_led,
    output logic              io_busy,
    output logic              io_frameDone
);

    localparam int TIMER_W = timerWidth(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

    blink_state_t        r_state;
    logic [CODE_W-1:0]   r_blinks;
    logic [CODE_W-1:0]   r_code;
    logic                r_led;
    logic                r_busy;
    logic                r_frameDone;

    blink_state_t        w_nextState;
    logic [CODE_W-1:0]   w_nextBlinks;
    logic [CODE_W-1:0]   w_nextCode;
    logic                w_startFrame;
    logic                w_load;
    logic [TIMER_W-1:0]  w_loadValue;
    logic                w_timerZero;
    logic [TIMER_W-1:0]  w_timerCount;
    logic                w_nextTimerZero;

    led_interval_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_loadValue(w_loadValue),
        .o_zero     (w_timerZero),
        .o_count    (w_timerCount)
    );

    // Next-state logic: abort has priority, otherwise walk the frame phases.
    // r_blinks counts blinks already started, so it is compared against the
    // latched code at the end of each ON phase and never exceeds the code.
    always_comb begin
        w_nextState  = r_state;
        w_nextBlinks = r_blinks;
        w_nextCode   = r_code;
        w_startFrame = 1'b0;
        w_load       = 1'b0;
        w_loadValue  = '0;

        if ((r_state != ST_IDLE) && !io_enable) begin
            w_nextState  = ST_IDLE;
            w_nextBlinks = '0;
            w_nextCode   = '0;
            w_load       = 1'b1;
            w_loadValue  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_enable) w_startFrame = 1'b1;
                end
                ST_ON: begin
                    if (w_timerZero) begin
                        w_load = 1'b1;
                        if (r_blinks == r_code) begin
                            w_nextState = ST_GAP;
                            w_loadValue = GAP_LOAD;
                        end else begin
                            w_nextState = ST_OFF;
                            w_loadValue = OFF_LOAD;
                        end
                    end
                end
                ST_OFF: begin
                    if (w_timerZero) begin
                        w_nextState  = ST_ON;
                        w_load       = 1'b1;
                        w_loadValue  = ON_LOAD;
                        w_nextBlinks = r_blinks + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_timerZero) w_startFrame = 1'b1;
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase

            if (w_startFrame) begin
                w_nextCode = io_code;
                w_load     = 1'b1;
                if (io_code != '0) begin
                    w_nextState  = ST_ON;
                    w_loadValue  = ON_LOAD;
                    w_nextBlinks = CODE_W'(1);
                end else begin
                    w_nextState  = ST_GAP;
                    w_loadValue  = GAP_LOAD;
                    w_nextBlinks = '0;
                end
            end
        end

        w_nextTimerZero = w_load ? (w_loadValue == '0) : (w_timerCount <= TIMER_W'(1));
    end

    // State, counters and output registers; outputs are computed from the
    // next state so they line up with the phase the FSM is in
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_blinks    <= '0;
            r_code      <= '0;
            r_led       <= ledLevel(1'b0, ACTIVE_HIGH);
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_blinks    <= w_nextBlinks;
            r_code      <= w_nextCode;
            r_led       <= ledLevel(w_nextState == ST_ON, ACTIVE_HIGH);
            r_busy      <= (w_nextState != ST_IDLE);
            r_frameDone <= (w_nextState == ST_GAP) && w_nextTimerZero;
        end
    end

    assign io_led       = r_led;
    assign io_busy      = r_busy;
    assign io_frameDone = r_frameDone;

endmodule
